// File: rtl/display_arbiter_if.sv
// Bus between the two message requesters and the HEX display arbiter.
// The requester side (master) offers level requests plus 18-bit frames.
// The arbiter side (slave) returns grants, done pulses and the frame for the decoders.
interface display_arbiter_if;
  logic        req_a_i;
  logic [17:0] codes_a_i;
  logic        req_b_i;
  logic [17:0] codes_b_i;
  logic        grant_a_o;
  logic        grant_b_o;
  logic        done_a_o;
  logic        done_b_o;
  logic [17:0] codes_o;

  modport master (
    output req_a_i, codes_a_i, req_b_i, codes_b_i,
    input  grant_a_o, grant_b_o, done_a_o, done_b_o, codes_o
  );

  modport slave (
    input  req_a_i, codes_a_i, req_b_i, codes_b_i,
    output grant_a_o, grant_b_o, done_a_o, done_b_o, codes_o
  );
endinterface

// File: rtl/display_arbiter.sv
// Round-robin time-sharing arbiter for the six HEX digits.
// A grant snapshots the winner's frame, holds it for HOLD_CYCLES cycles, and
// pulses done on the last cycle. At least one IDLE cycle separates grants.
module display_arbiter #(
  parameter int unsigned HOLD_CYCLES = 50_000_000
) (
  input  logic                clk_i,
  input  logic                reset_i,
  display_arbiter_if.slave    bus
);

  // The counter only ever holds values 0..HOLD_CYCLES-1, so it never wraps.
  localparam int unsigned   CW         = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD       = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] ONE        = CW'(1);
  // With a one-cycle dwell the entry cycle is also the last cycle.
  localparam logic          FIRST_DONE = (HOLD_CYCLES == 1);

  typedef enum logic [1:0] {IDLE, SHOW_A, SHOW_B} state_t;

  state_t        state_q;
  logic          last_b_q;
  logic [CW-1:0] cnt_q;
  logic          grant_a_q;
  logic          grant_b_q;
  logic          done_a_q;
  logic          done_b_q;
  logic [17:0]   codes_q;

  logic          pick_a_d;
  logic          pick_b_d;

  // Tie-break: the requester that was not served last wins.
  always_comb begin
    pick_a_d = bus.req_a_i & (~bus.req_b_i | last_b_q);
    pick_b_d = bus.req_b_i & (~bus.req_a_i | ~last_b_q);
  end

  // Arbitration FSM with the dwell counter and all registered outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      last_b_q  <= 1'b1;
      cnt_q     <= '0;
      grant_a_q <= 1'b0;
      grant_b_q <= 1'b0;
      done_a_q  <= 1'b0;
      done_b_q  <= 1'b0;
      codes_q   <= '0;
    end else begin
      done_a_q <= 1'b0;
      done_b_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_a_d) begin
            state_q   <= SHOW_A;
            grant_a_q <= 1'b1;
            codes_q   <= bus.codes_a_i;
            cnt_q     <= LOAD;
            last_b_q  <= 1'b0;
            done_a_q  <= FIRST_DONE;
          end else if (pick_b_d) begin
            state_q   <= SHOW_B;
            grant_b_q <= 1'b1;
            codes_q   <= bus.codes_b_i;
            cnt_q     <= LOAD;
            last_b_q  <= 1'b1;
            done_b_q  <= FIRST_DONE;
          end
        end
        SHOW_A, SHOW_B: begin
          // Requests and incoming frames are ignored until the dwell expires.
          if (cnt_q == '0) begin
            state_q   <= IDLE;
            grant_a_q <= 1'b0;
            grant_b_q <= 1'b0;
            codes_q   <= '0;
          end else begin
            cnt_q <= cnt_q - ONE;
            if (cnt_q == ONE) begin
              done_a_q <= (state_q == SHOW_A);
              done_b_q <= (state_q == SHOW_B);
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          grant_a_q <= 1'b0;
          grant_b_q <= 1'b0;
          codes_q   <= '0;
        end
      endcase
    end
  end

  assign bus.grant_a_o = grant_a_q;
  assign bus.grant_b_o = grant_b_q;
  assign bus.done_a_o  = done_a_q;
  assign bus.done_b_o  = done_b_q;
  assign bus.codes_o   = codes_q;

endmodule
